sd_drive_arbiter: RTL
=====================

# sd_drive_arbiter

Parametrised arbiter between up to NBDRIV virtual-disk clients in the TRS-80 core and the hps_io SD block-transfer port. It replaces the fixed fan-out/OR-ing of sd_lba, sd_ack and sd_buff_din. Only one drive's sector request is presented to hps_io at a time, chosen round-robin. Acks and buffer-write strobes are routed back to the owning drive only. It adds mount tracking, a per-request timeout, and done/error reporting.

## Interface
- NBDRIV, 4, number of drives (1..8)
- LBA_W, 32, sector address width
- TMO_W, 24, timeout counter width; a request aborts after 2^TMO_W-1 cycles without ack
- clk_sys  in  1  system clock (42 MHz)
- reset_n  in  1  reset, asynchronous, active-low
- drv_lba  in  NBDRIV×LBA_W  per-drive sector address, valid while drv_rd/drv_wr high
- drv_rd, drv_wr  in  NBDRIV  per-drive level requests, held until drv_done or drv_err
- drv_buff_din  in  NBDRIV×8  per-drive write-buffer data
- drv_ack  out  NBDRIV  sd_ack of the granted drive, routed to that drive only
- drv_buff_wr  out  NBDRIV  sd_buff_wr gated to the granted drive
- drv_done, drv_err  out  NBDRIV  one-cycle completion / failure pulses
- img_mounted  in  NBDRIV  mount pulses from hps_io
- img_size  in  64  image size qualifying img_mounted
- sd_lba  out  NBDRIV×LBA_W  latched LBA on every lane
- sd_rd, sd_wr  out  NBDRIV  one-hot request to hps_io
- sd_ack  in  NBDRIV  hps_io acknowledge
- sd_buff_wr  in  1  hps_io buffer write strobe
- sd_buff_din  out  NBDRIV×8  lane i = drv_buff_din[i] (combinational)
- busy  out  1  state ≠ IDLE
- grant  out  3  index of the current or most recent drive

## Operation
- States: IDLE, REQ, XFER, DONE.
- Mount tracking, per drive:
  - img_mounted[i] with img_size≠0 sets mounted[i].
  - img_mounted[i] with img_size==0 clears mounted[i].
  - Reset clears all mounted flags.
- IDLE:
  - Pending set p[i] = drv_rd[i]|drv_wr[i].
  - Pick the first i with p[i] set, scanning from ptr upward with wrap.
  - If the picked drive is unmounted, pulse drv_err[i], advance ptr=i+1, stay IDLE.
  - Otherwise latch lba=drv_lba[i], op=rd (drv_rd wins if both are high; wr stays pending), grant=i, clear the timeout counter, go to REQ.
- REQ:
  - sd_rd[grant] or sd_wr[grant] is held high; all other lanes are 0.
  - sd_ack[grant] rising goes to XFER and drops sd_rd/sd_wr in the same edge.
  - Timeout counter saturating goes to IDLE with a drv_err[grant] pulse and ptr=grant+1.
- XFER:
  - drv_ack[grant]=sd_ack[grant]; drv_buff_wr[grant]=sd_buff_wr.
  - sd_ack[grant] falling goes to DONE.
- DONE: pulse drv_done[grant] for one cycle, ptr=grant+1 (wrapping at NBDRIV), go to IDLE.
- Unmount during REQ/XFER: sd_rd/sd_wr drop immediately; the transfer continues until ack falls; drv_err pulses instead of drv_done.
- sd_ack on a non-granted lane is ignored and never forwarded.
- A client dropping its request mid-REQ still completes via the ack path (hps_io cannot be cancelled).

## Timing
- Reset (async assert, sync release), all outputs 0:
  - sd_rd, sd_wr, sd_lba, drv_ack, drv_buff_wr, drv_done, drv_err, busy = 0.
  - grant=0, ptr=0, state=IDLE.
- Request seen in IDLE at edge n: sd_rd/sd_wr high from edge n+1 (registered).
- sd_ack rise at edge m: sd_rd/sd_wr low after edge m; drv_ack is combinational from sd_ack and gated by a registered grant.
- sd_ack fall at edge k: drv_done pulses for cycle k+1; next arbitration in cycle k+2.
- Back-to-back requests from other drives: 3 idle cycles minimum between successive sd_ack windows.
- Timeout: drv_err pulses exactly 2^TMO_W-1 cycles after entering REQ.
- Mount pulse and request in the same cycle: the updated mounted flag is used the next cycle; the request is evaluated after the update.

## Structure
- Package sd_arb_pkg holds the state enum (IDLE/REQ/XFER/DONE) and the default NBDRIV/LBA_W constants shared with the top level.
- One sub-module, rr_pick: a combinational round-robin first-set finder (request vector plus ptr, producing an index and a valid flag), reusable elsewhere.
- The arbiter holds the FSM, latches, timeout counter, mounted flags and lane routing.

## Test plan
- Mount drive 1 (size 0x2D000); drv_rd[1] with lba 0x12 → sd_rd=4'b0010 and sd_lba[1]=0x12 next cycle; ack for 5 cycles with 3 sd_buff_wr strobes → drv_buff_wr[1] ×3, drv_done[1] one cycle after ack falls.
- Drives 0, 2 and 3 mounted, all request simultaneously with ptr=0 → service order 0, 2, 3; no overlapping sd_rd bits; ptr ends at 0.
- drv_rd[2] on an unmounted drive → drv_err[2] pulse within 2 cycles; sd_rd stays 0.
- TMO_W=4 and no sd_ack → drv_err pulse 15 cycles after REQ entry; arbiter returns to IDLE.
- drv_rd[0] and drv_wr[0] both high → the read is served first, then the write on the next arbitration.
- reset_n low mid-XFER → all outputs 0 asynchronously; after release, a new request is served normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared types and defaults for the SD drive arbiter.
//   arb_state_e    - arbiter FSM states
//   DEF_NBDRIV     - default number of virtual drives
//   DEF_LBA_W      - default sector address width
//   DEF_TMO_W      - default timeout counter width
//   IDX_W          - width of drive index / grant / round-robin pointer (up to 8 drives)
//   wrap_inc()     - next round-robin pointer after a given drive
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam int DEF_NBDRIV = 4;
    localparam int DEF_LBA_W  = 32;
    localparam int DEF_TMO_W  = 24;
    localparam int IDX_W      = 3;

    // Pointer to the drive after i, wrapping at n drives.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
        logic [IDX_W-1:0] r;
        if (int'(i) >= n - 1) r = '0;
        else                  r = i + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin first-set finder.
//   req - request vector (N bits)
//   ptr - index where the scan starts; the scan wraps past N-1 back to 0
//   idx - first set request found from ptr upward
//   vld - at least one request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          vld
);

    // Scan offset k from ptr; lane m sits at offset k when ptr == (m - k) mod N.
    // All indices are loop constants, so this unrolls to a plain priority tree.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < N; m++) begin
                if (!vld && req[m] && (ptr == IW'((m - k + N) % N))) begin
                    vld = 1'b1;
                    idx = IW'(m);
                end
            end
        end
    end

endmodule

// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: round-robin arbiter between NBDRIV virtual-disk clients
// and the hps_io SD block-transfer port.
//   clk_sys, reset_n        - clock, async active-low reset
//   drv_lba/drv_rd/drv_wr   - per-drive level requests (held until done/err)
//   drv_buff_din            - per-drive write data, passed straight to sd_buff_din
//   drv_ack/drv_buff_wr     - sd_ack / sd_buff_wr routed to the granted drive only
//   drv_done/drv_err        - one-cycle completion / failure pulses
//   img_mounted/img_size    - mount (size != 0) and unmount (size == 0) pulses
//   sd_lba/sd_rd/sd_wr      - latched LBA on every lane, one-hot request
//   sd_ack/sd_buff_wr       - hps_io acknowledge and buffer write strobe
//   busy/grant              - FSM not idle, current or last served drive
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NBDRIV = DEF_NBDRIV,
    parameter int LBA_W  = DEF_LBA_W,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic [NBDRIV-1:0][LBA_W-1:0]   drv_lba,
    input  logic [NBDRIV-1:0]              drv_rd,
    input  logic [NBDRIV-1:0]              drv_wr,
    input  logic [NBDRIV-1:0][7:0]         drv_buff_din,
    output logic [NBDRIV-1:0]              drv_ack,
    output logic [NBDRIV-1:0]              drv_buff_wr,
    output logic [NBDRIV-1:0]              drv_done,
    output logic [NBDRIV-1:0]              drv_err,
    input  logic [NBDRIV-1:0]              img_mounted,
    input  logic [63:0]                    img_size,
    output logic [NBDRIV-1:0][LBA_W-1:0]   sd_lba,
    output logic [NBDRIV-1:0]              sd_rd,
    output logic [NBDRIV-1:0]              sd_wr,
    input  logic [NBDRIV-1:0]              sd_ack,
    input  logic                           sd_buff_wr,
    output logic [NBDRIV-1:0][7:0]         sd_buff_din,
    output logic                           busy,
    output logic [2:0]                     grant
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, ptr_q, pick_idx;
    logic               pick_vld;
    logic [NBDRIV-1:0]  pend, pick_vec, gvec, mounted_q, err_q, mount_set, mount_clr;
    logic [LBA_W-1:0]   lba_q, pick_lba;
    logic               op_wr_q, req_q, abort_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               pick_mounted, pick_rd, mount_evt, ack_g, g_unmount;
    logic               tmo_sat, tmo_err, route;

    // A drive whose error pulse is showing is masked for that cycle so a
    // client dropping its request on the pulse is not re-flagged.
    assign pend = (drv_rd | drv_wr) & ~err_q;

    rr_pick #(.N(NBDRIV), .IW(IDX_W)) u_pick (
        .req (pend),
        .ptr (ptr_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        mount_set    = img_mounted & {NBDRIV{img_size != 64'd0}};
        mount_clr    = img_mounted & {NBDRIV{img_size == 64'd0}};
        // Any mount activity defers arbitration one cycle so the request is
        // judged against the updated mounted flags.
        mount_evt    = |img_mounted;
        pick_mounted = |(pick_vec & mounted_q);
        pick_rd      = |(pick_vec & drv_rd);
        ack_g        = |(sd_ack & gvec);
        g_unmount    = |(mount_clr & gvec);
        tmo_sat      = &tmo_q;
        tmo_err      = (state_q == REQ) && tmo_sat && !ack_g;
        route        = (state_q == REQ) || (state_q == XFER);
        pick_lba     = '0;
        for (int i = 0; i < NBDRIV; i++) begin
            if (pick_vec[i]) pick_lba = drv_lba[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pick_vld && !mount_evt && pick_mounted) state_d = REQ;
            REQ: begin
                if (ack_g)        state_d = XFER;
                else if (tmo_sat) state_d = IDLE;
            end
            XFER: if (!ack_g) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            lba_q     <= '0;
            op_wr_q   <= 1'b0;
            req_q     <= 1'b0;
            abort_q   <= 1'b0;
            tmo_q     <= '0;
            err_q     <= '0;
            mounted_q <= '0;
        end else begin
            state_q   <= state_d;
            mounted_q <= (mounted_q | mount_set) & ~mount_clr;
            err_q     <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld && !mount_evt) begin
                        if (!pick_mounted) begin
                            err_q <= pick_vec;
                            ptr_q <= wrap_inc(pick_idx, NBDRIV);
                        end else begin
                            grant_q <= pick_idx;
                            lba_q   <= pick_lba;
                            op_wr_q <= !pick_rd;   // read wins; write stays pending
                            req_q   <= 1'b1;
                            abort_q <= 1'b0;
                            tmo_q   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (!tmo_sat) tmo_q <= tmo_q + 1'b1;
                    if (ack_g || tmo_sat) req_q <= 1'b0;
                    if (tmo_sat && !ack_g) ptr_q <= wrap_inc(grant_q, NBDRIV);
                end
                XFER: ;
                DONE: ptr_q <= wrap_inc(grant_q, NBDRIV);
                default: ;
            endcase
            // hps_io cannot be cancelled: an unmount only withdraws the request
            // and turns the eventual completion into an error.
            if (route && g_unmount) begin
                abort_q <= 1'b1;
                req_q   <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NBDRIV; i++) begin : g_lane
        assign gvec[i]        = (grant_q == IDX_W'(i));
        assign pick_vec[i]    = (pick_idx == IDX_W'(i));
        assign sd_lba[i]      = lba_q;
        assign sd_buff_din[i] = drv_buff_din[i];
        // The unmount term drops the request in the same cycle as the pulse.
        assign sd_rd[i]       = req_q & ~op_wr_q & gvec[i] & ~abort_q & ~mount_clr[i];
        assign sd_wr[i]       = req_q &  op_wr_q & gvec[i] & ~abort_q & ~mount_clr[i];
        assign drv_ack[i]     = route & gvec[i] & sd_ack[i];
        assign drv_buff_wr[i] = route & gvec[i] & sd_buff_wr;
        assign drv_done[i]    = (state_q == DONE) & ~abort_q & gvec[i];
        assign drv_err[i]     = err_q[i] | (gvec[i] & (tmo_err | ((state_q == DONE) & abort_q)));
    end

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

endmodule
